card_select_ctrl: RTL and testbench
===================================

CARD_SELECT_CTRL -- requirements
Module: card_select_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 25_000_000, sets the number of clk cycles both picked cards stay face-up before resolution.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port new_game, input, 1, pulse that synchronously clears all board flags and returns the block to IDLE.
REQ-005 SHALL have port start_turn, input, 1, pulse that opens a turn of two picks.
REQ-006 SHALL have ports btn_next, btn_prev, btn_sel, input, 1 each, debounced single-cycle pulses.
REQ-007 SHALL have port timeout, input, 1, pulse from the turn timer.
REQ-008 SHALL have port rd_addr, output, 4, board RAM address; card_val, input, 3, card value at rd_addr, valid in the same cycle.
REQ-009 SHALL have ports cursor, output, 4; face_up, output, 16; matched, output, 16; busy, output, 1.
REQ-010 SHALL have ports picked, output, 1 (pulse per accepted card); pair_done, output, 1 (pulse); pair_match, output, 1 (valid with pair_done); all_matched, output, 1.

Function
REQ-011 SHALL implement states IDLE, WAIT1, WAIT2, SCAN, COMPARE, SHOW, RESOLVE.
REQ-012 In IDLE, start_turn SHALL move to WAIT1; busy SHALL be 0 only in IDLE.
REQ-013 btn_next SHALL increment cursor mod 16 (15->0); btn_prev SHALL decrement it mod 16 (0->15); both asserted together SHALL leave cursor unchanged; cursor moves in every state.
REQ-014 A card is eligible when its matched and face_up bits are both 0.
REQ-015 In WAIT1/WAIT2, btn_sel on an eligible cursor card SHALL set face_up[cursor], pulse picked for 1 cycle and advance (WAIT1->WAIT2, WAIT2->COMPARE); btn_sel on an ineligible card SHALL be ignored.
REQ-016 btn_sel and timeout in the same cycle SHALL be treated as btn_sel only.
REQ-017 timeout in WAIT1 or WAIT2 SHALL enter SCAN with scan pointer = lfsr[3:0] and remaining picks = 2 or 1 respectively.
REQ-018 SCAN SHALL test one address per cycle; if eligible, it SHALL set face_up, pulse picked and decrement remaining picks (to COMPARE at 0, else continue from pointer+1); if not, pointer increments mod 16.
REQ-019 timeout while all_matched=1, or in any state other than WAIT1/WAIT2, SHALL be ignored.
REQ-020 The lfsr SHALL be 8-bit Fibonacci, taps 8,6,5,4, reset seed 8'h01, advancing every cycle.
REQ-021 The block SHALL record the two picked addresses in pick order; COMPARE SHALL drive rd_addr to the first pick for one cycle, latch card_val, then drive the second pick and set the match flag when values are equal (2 cycles total).
REQ-022 rd_addr SHALL be 0 outside COMPARE.
REQ-023 SHOW SHALL hold face_up unchanged for exactly SHOW_CYCLES cycles, then enter RESOLVE.
REQ-024 RESOLVE SHALL last 1 cycle: pulse pair_done, drive pair_match, on match set both matched bits, clear both face_up bits, return to IDLE.
REQ-025 all_matched SHALL equal 1 exactly when matched == 16'hFFFF.
REQ-026 start_turn outside IDLE SHALL be ignored.
REQ-027 new_game SHALL take priority over all other inputs in any state.

Reset
REQ-028 On rst: state IDLE, cursor 0, face_up 0, matched 0, lfsr 8'h01, picked/pair_done/pair_match/busy/all_matched 0, rd_addr 0.
REQ-029 rst asserted mid-turn SHALL abort immediately with no pair_done pulse.

Verification
REQ-030 Bench board card_val = rd_addr>>1. Sequence: start_turn, sel at 0, next, sel at 1 -> 2 picked pulses, pair_match=1 after SHOW_CYCLES+3 cycles, matched=16'h0003, face_up=0.
REQ-031 sel at 0, then sel at 2 -> pair_done with pair_match=0, matched unchanged, face_up returns to 0.
REQ-032 cursor 0 with btn_prev -> 15; cursor 15 with btn_next -> 0; next+prev together -> unchanged.
REQ-033 timeout in WAIT1 -> two picked pulses on distinct eligible addresses, then COMPARE; btn_sel+timeout same cycle -> only the cursor card is picked.
REQ-034 With cards 0 and 1 matched, btn_sel at 0 -> no picked pulse, state stays WAIT1.
REQ-035 After all 8 pairs are matched -> all_matched=1 and timeout is ignored; new_game mid-SHOW -> IDLE and all flags 0.

Source files
------------

// File: rtl/card_select_ctrl.sv
// Card-pick controller for a 16-card memory game: cursor navigation, two picks per turn
// (by button or timed-out auto scan), value compare through the board RAM, show delay, resolve.
module card_select_ctrl #(
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        start_turn,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        btn_sel,
    input  logic        timeout,
    output logic [3:0]  rd_addr,
    input  logic [2:0]  card_val,
    output logic [3:0]  cursor,
    output logic [15:0] face_up,
    output logic [15:0] matched,
    output logic        busy,
    output logic        picked,
    output logic        pair_done,
    output logic        pair_match,
    output logic        all_matched
);

    localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CW-1:0] SHOW_LOAD = CW'(SHOW_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT1, S_WAIT2, S_SCAN, S_COMPARE, S_SHOW, S_RESOLVE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_lfsr;
    logic [3:0]      r_cursor;
    logic [15:0]     r_face_up;
    logic [15:0]     r_matched;
    logic [3:0]      r_scan_ptr;
    logic [1:0]      r_remain;
    logic [3:0]      r_pick0;
    logic [3:0]      r_pick1;
    logic [2:0]      r_val0;
    logic            r_cmp_phase;
    logic            r_match;
    logic            r_picked;
    logic [CW-1:0]   r_show_cnt;

    logic            w_cur_elig;
    logic            w_scan_elig;
    logic            w_all_matched;
    logic            w_accept;
    logic [3:0]      w_accept_addr;
    logic            w_first_pick;
    logic            w_to_scan;
    logic [3:0]      w_rd_addr;
    logic            w_fb;

    assign w_cur_elig    = ~r_matched[r_cursor] & ~r_face_up[r_cursor];
    assign w_scan_elig   = ~r_matched[r_scan_ptr] & ~r_face_up[r_scan_ptr];
    assign w_all_matched = (r_matched == 16'hFFFF);
    assign w_first_pick  = (r_state == S_WAIT1) || ((r_state == S_SCAN) && (r_remain == 2'd2));
    assign w_fb          = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_accept_addr = r_cursor;
        w_to_scan     = 1'b0;
        w_rd_addr     = 4'd0;
        case (r_state)
            S_IDLE: if (start_turn) w_state_nxt = S_WAIT1;
            S_WAIT1, S_WAIT2: begin
                // A select press wins over a simultaneous timeout, even when it hits a dead card.
                if (btn_sel) begin
                    if (w_cur_elig) begin
                        w_accept    = 1'b1;
                        w_state_nxt = (r_state == S_WAIT1) ? S_WAIT2 : S_COMPARE;
                    end
                end else if (timeout && !w_all_matched) begin
                    w_to_scan   = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                w_accept_addr = r_scan_ptr;
                if (w_scan_elig) begin
                    w_accept = 1'b1;
                    if (r_remain == 2'd1) w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_rd_addr = r_cmp_phase ? r_pick1 : r_pick0;
                if (r_cmp_phase) w_state_nxt = S_SHOW;
            end
            S_SHOW:    if (r_show_cnt == '0) w_state_nxt = S_RESOLVE;
            S_RESOLVE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (new_game) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_to_scan   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr      <= 8'h01;
            r_cursor    <= 4'd0;
            r_face_up   <= 16'h0000;
            r_matched   <= 16'h0000;
            r_scan_ptr  <= 4'd0;
            r_remain    <= 2'd0;
            r_pick0     <= 4'd0;
            r_pick1     <= 4'd0;
            r_val0      <= 3'd0;
            r_cmp_phase <= 1'b0;
            r_match     <= 1'b0;
            r_picked    <= 1'b0;
            r_show_cnt  <= '0;
        end else begin
            r_lfsr   <= {r_lfsr[6:0], w_fb};
            r_picked <= w_accept;
            if (btn_next && !btn_prev)      r_cursor <= r_cursor + 4'd1;
            else if (btn_prev && !btn_next) r_cursor <= r_cursor - 4'd1;

            if (new_game) begin
                r_face_up   <= 16'h0000;
                r_matched   <= 16'h0000;
                r_cmp_phase <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_face_up[w_accept_addr] <= 1'b1;
                    if (w_first_pick) r_pick0 <= w_accept_addr;
                    else              r_pick1 <= w_accept_addr;
                end
                if (w_to_scan) begin
                    r_scan_ptr <= r_lfsr[3:0];
                    r_remain   <= (r_state == S_WAIT1) ? 2'd2 : 2'd1;
                end
                case (r_state)
                    S_SCAN: begin
                        r_scan_ptr <= r_scan_ptr + 4'd1;
                        if (w_accept) r_remain <= r_remain - 2'd1;
                    end
                    S_COMPARE: begin
                        r_cmp_phase <= ~r_cmp_phase;
                        if (!r_cmp_phase) begin
                            r_val0 <= card_val;
                        end else begin
                            r_match    <= (card_val == r_val0);
                            r_show_cnt <= SHOW_LOAD;
                        end
                    end
                    S_SHOW: if (r_show_cnt != '0) r_show_cnt <= r_show_cnt - 1'b1;
                    S_RESOLVE: begin
                        if (r_match) begin
                            r_matched[r_pick0] <= 1'b1;
                            r_matched[r_pick1] <= 1'b1;
                        end
                        r_face_up[r_pick0] <= 1'b0;
                        r_face_up[r_pick1] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_addr     = w_rd_addr;
    assign cursor      = r_cursor;
    assign face_up     = r_face_up;
    assign matched     = r_matched;
    assign busy        = (r_state != S_IDLE);
    assign picked      = r_picked;
    assign pair_done   = (r_state == S_RESOLVE);
    assign pair_match  = (r_state == S_RESOLVE) && r_match;
    assign all_matched = w_all_matched;

endmodule

// File: tb/tb_card_select_ctrl.sv
// Scoreboard bench for card_select_ctrl: stimulus pushes expected picked/pair_done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_card_select_ctrl;

    localparam int SHOW = 4;
    localparam int K_PICK = 0;
    localparam int K_PAIR = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_game = 0, start_turn = 0, btn_next = 0, btn_prev = 0, btn_sel = 0, timeout = 0;
    logic [3:0]  rd_addr;
    logic [2:0]  card_val;
    logic [3:0]  cursor;
    logic [15:0] face_up, matched;
    logic        busy, picked, pair_done, pair_match, all_matched;

    typedef struct {
        int          kind;
        logic [15:0] v;
    } ev_t;
    ev_t q[$];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_pick_cyc = 0;
    logic [3:0]  exp_cur = 4'd0;
    logic [15:0] exp_matched = 16'h0000;
    logic [7:0]  m_lfsr;

    always #5 clk = ~clk;

    // Board: each pair of adjacent addresses holds the same value.
    assign card_val = rd_addr[3:1];

    card_select_ctrl #(.SHOW_CYCLES(SHOW)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .start_turn(start_turn),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_sel(btn_sel), .timeout(timeout),
        .rd_addr(rd_addr), .card_val(card_val), .cursor(cursor), .face_up(face_up),
        .matched(matched), .busy(busy), .picked(picked), .pair_done(pair_done),
        .pair_match(pair_match), .all_matched(all_matched)
    );

    // Reference lfsr: 8-bit Fibonacci, taps 8,6,5,4, seed 01.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'h01;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic ng, input logic st, input logic nx, input logic pv,
                         input logic sl, input logic to);
        new_game = ng; start_turn = st; btn_next = nx; btn_prev = pv; btn_sel = sl; timeout = to;
        if (nx && !pv)      exp_cur = exp_cur + 4'd1;
        else if (pv && !nx) exp_cur = exp_cur - 4'd1;
        step();
        new_game = 0; start_turn = 0; btn_next = 0; btn_prev = 0; btn_sel = 0; timeout = 0;
    endtask

    task automatic push(input int kind, input logic [15:0] v);
        ev_t e;
        e.kind = kind;
        e.v    = v;
        q.push_back(e);
    endtask

    task automatic move_to(input logic [3:0] t);
        while (exp_cur != t) press(0, 0, 1, 0, 0, 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            check({name, "_drain_timeout"}, q.size(), 0);
            q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_matched"}, matched, exp_matched);
        check({name, "_face_up"}, face_up, 16'h0000);
        check({name, "_busy"}, busy, 0);
        check({name, "_rd_addr"}, rd_addr, 0);
    endtask

    function automatic logic [3:0] find_elig(input logic [3:0] start, input logic [15:0] mask);
        logic [3:0] a;
        a = start;
        for (int i = 0; i < 16; i++) begin
            if (mask[a]) return a;
            a = a + 4'd1;
        end
        return start;
    endfunction

    // Monitor: every picked/pair_done pulse must match the head of the queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && picked) begin
                if (q.size() == 0) check("picked_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    check("pick_kind", e.kind, K_PICK);
                    check("pick_face_up", face_up, e.v);
                    last_pick_cyc = cyc;
                end
            end
            if (!rst && pair_done) begin
                if (q.size() == 0) check("pair_done_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    check("pair_kind", e.kind, K_PAIR);
                    check("pair_match", pair_match, e.v[0]);
                    // Second select lands in cycle k; pair_done is in cycle k+SHOW+3.
                    check("pair_latency", cyc - last_pick_cyc, SHOW + 2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  a, b, c, c2;
        logic [15:0] elig;

        step(); step();
        check("rst_cursor", cursor, 0);
        check("rst_face_up", face_up, 0);
        check("rst_matched", matched, 0);
        check("rst_busy", busy, 0);
        check("rst_all_matched", all_matched, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_picked", picked, 0);
        check("rst_pair", {pair_done, pair_match}, 0);
        rst = 0;
        step();

        // Mismatched pair: cards 0 and 2.
        press(0, 1, 0, 0, 0, 0);
        check("turn_busy", busy, 1);
        push(K_PICK, 16'h0001);
        press(0, 0, 0, 0, 1, 0);
        move_to(4'd2);
        push(K_PICK, 16'h0005);
        push(K_PAIR, 16'h0000);
        press(0, 0, 0, 0, 1, 0);
        drain("mismatch");
        check_idle("mismatch");

        // Matching pair: cards 0 and 1.
        press(0, 0, 0, 1, 0, 0);
        press(0, 0, 0, 1, 0, 0);
        check("cursor_back0", cursor, 0);
        press(0, 1, 0, 0, 0, 0);
        push(K_PICK, 16'h0001);
        press(0, 0, 0, 0, 1, 0);
        press(0, 0, 1, 0, 0, 0);
        push(K_PICK, 16'h0003);
        push(K_PAIR, 16'h0001);
        press(0, 0, 0, 0, 1, 0);
        drain("match");
        exp_matched = 16'h0003;
        check_idle("match");

        // Select on a matched card is ignored; block stays in WAIT1.
        press(0, 0, 0, 1, 0, 0);
        press(0, 1, 0, 0, 0, 0);
        press(0, 0, 0, 0, 1, 0);
        step(); step();
        check("inelig_face_up", face_up, 0);
        check("inelig_busy", busy, 1);
        move_to(4'd2);
        push(K_PICK, 16'h0004);
        press(0, 0, 0, 0, 1, 0);
        press(0, 0, 1, 0, 0, 0);
        push(K_PICK, 16'h000C);
        push(K_PAIR, 16'h0001);
        press(0, 0, 0, 0, 1, 0);
        drain("inelig");
        exp_matched = 16'h000F;
        check_idle("inelig");

        // Cursor wrap and simultaneous next/prev.
        press(0, 0, 1, 1, 0, 0);
        check("cursor_both", cursor, 4'd3);
        move_to(4'd0);
        press(0, 0, 0, 1, 0, 0);
        check("cursor_wrap_dn", cursor, 4'd15);
        press(0, 0, 1, 0, 0, 0);
        check("cursor_wrap_up", cursor, 4'd0);

        // Timeout in WAIT1: auto scan from the lfsr value sampled at the timeout edge.
        press(0, 1, 0, 0, 0, 0);
        elig = ~exp_matched;
        a = find_elig(m_lfsr[3:0], elig);
        b = find_elig(a + 4'd1, elig & ~(16'h0001 << a));
        push(K_PICK, 16'h0001 << a);
        push(K_PICK, (16'h0001 << a) | (16'h0001 << b));
        push(K_PAIR, {15'd0, a[3:1] == b[3:1]});
        press(0, 0, 0, 0, 0, 1);
        drain("scan");
        if (a[3:1] == b[3:1]) exp_matched = exp_matched | (16'h0001 << a) | (16'h0001 << b);
        check_idle("scan");

        // Select and timeout together: only the cursor card is picked.
        c = find_elig(4'd0, ~exp_matched);
        move_to(c);
        press(0, 1, 0, 0, 0, 0);
        push(K_PICK, 16'h0001 << c);
        press(0, 0, 0, 0, 1, 1);
        c2 = c ^ 4'd1;
        move_to(c2);
        push(K_PICK, (16'h0001 << c) | (16'h0001 << c2));
        push(K_PAIR, 16'h0001);
        press(0, 0, 0, 0, 1, 0);
        drain("sel_to");
        exp_matched = exp_matched | (16'h0001 << c) | (16'h0001 << c2);
        check_idle("sel_to");

        // Finish the board by hand.
        for (int p = 0; p < 8; p++) begin
            if (!exp_matched[2*p]) begin
                c = 4'(2*p);
                move_to(c);
                press(0, 1, 0, 0, 0, 0);
                push(K_PICK, 16'h0001 << c);
                press(0, 0, 0, 0, 1, 0);
                press(0, 0, 1, 0, 0, 0);
                push(K_PICK, 16'h0003 << c);
                push(K_PAIR, 16'h0001);
                press(0, 0, 0, 0, 1, 0);
                drain("fill");
                exp_matched = exp_matched | (16'h0003 << c);
            end
        end
        check("full_matched", matched, 16'hFFFF);
        check("all_matched", all_matched, 1);

        // Timeout on a full board does nothing; new_game clears it.
        press(0, 1, 0, 0, 0, 0);
        press(0, 0, 0, 0, 0, 1);
        repeat (10) step();
        check("full_to_busy", busy, 1);
        check("full_to_face_up", face_up, 0);
        press(1, 0, 0, 0, 0, 0);
        exp_matched = 16'h0000;
        check("ng_all_matched", all_matched, 0);
        check_idle("ng_wait1");

        // new_game during SHOW: abort with no pair_done.
        c = exp_cur;
        c2 = c + 4'd1;
        press(0, 1, 0, 0, 0, 0);
        push(K_PICK, 16'h0001 << c);
        press(0, 0, 0, 0, 1, 0);
        press(0, 0, 1, 0, 0, 0);
        push(K_PICK, (16'h0001 << c) | (16'h0001 << c2));
        press(0, 0, 0, 0, 1, 0);
        repeat (3) step();
        check("show_busy", busy, 1);
        check("show_face_up", face_up, (16'h0001 << c) | (16'h0001 << c2));
        press(1, 0, 0, 0, 0, 0);
        check_idle("ng_show");
        repeat (SHOW + 6) step();

        // Reset mid-turn: immediate abort, no pair_done.
        c = exp_cur;
        c2 = c + 4'd1;
        press(0, 1, 0, 0, 0, 0);
        push(K_PICK, 16'h0001 << c);
        press(0, 0, 0, 0, 1, 0);
        press(0, 0, 1, 0, 0, 0);
        push(K_PICK, (16'h0001 << c) | (16'h0001 << c2));
        press(0, 0, 0, 0, 1, 0);
        step();
        rst = 1;
        #2;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_face_up", face_up, 0);
        check("rst_mid_cursor", cursor, 0);
        check("rst_mid_pair_done", pair_done, 0);
        step();
        rst = 0;
        exp_cur = 4'd0;
        repeat (SHOW + 6) step();
        check("end_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
